hub75_scan_engine: RTL and testbench
====================================

Name: hub75_scan_engine

Overview:
Parametrised HUB75 panel scan engine, successor to the fixed 64x32 single-mode controller. It reads pixel pairs (top and bottom half) from a double-buffered frame RAM read port. It drives the panel with binary-coded modulation over BITS_PER_CHANNEL bit planes, with global brightness scaling. It also performs a frame-synchronous buffer swap handshake with the writer side. Panel width, scan depth, colour depth, shift-clock rate and on-time base are all parameters.

Parameters:
COLS, 64, pixels per panel row (power of two, >=4)
ROW_ADDR_BITS, 4, width of hub75_addr; scan rows = 2**ROW_ADDR_BITS
BITS_PER_CHANNEL, 4, bit planes per colour (1..8)
CLK_DIV, 2, clk cycles per hub75_clk half-period (>=1)
BASE_ON, 32, OE-low clk cycles for plane 0 at full brightness
BLANK_CYCLES, 2, clk cycles with OE high before and after address/latch change

Ports:
clk  in  1  system clock; all logic on posedge
n_reset  in  1  asynchronous active-low reset
enable  in  1  run request; sampled only at frame boundary
brightness  in  8  global brightness; 255 = full
swap_req  in  1  level; writer requests buffer flip
swap_ack  out  1  one-clk pulse when flip taken
rd_buf  out  1  buffer currently displayed (RAM address MSB)
rd_addr  out  ROW_ADDR_BITS+log2(COLS)  {row, column} read address
rd_data_top  in  3*BITS_PER_CHANNEL  {R,G,B} pixel for the top half; valid 1 clk after rd_addr
rd_data_bottom  in  3*BITS_PER_CHANNEL  same for bottom half
hub75_red/green/blue  out  2 each  {bottom, top} bit of current plane
hub75_addr  out  ROW_ADDR_BITS  scan row
hub75_clk  out  1  panel shift clock
hub75_latch  out  1  panel latch
hub75_oe  out  1  panel output enable, active low
frame_start  out  1  one-clk pulse at start of row 0, plane 0 shift

Behaviour:
- Async reset (n_reset low): all colour outputs 0, hub75_addr 0, hub75_clk 0, hub75_latch 0, hub75_oe 1, swap_ack 0, rd_buf 0, frame_start 0, rd_addr 0. State goes to IDLE, plane 0, row 0. Reset applies immediately even mid-shift or mid-display.
- States: IDLE, SHIFT, BLANK_PRE, LATCH, DISPLAY, BLANK_POST.
- IDLE: oe=1, hub75_clk=0. If enable=1, go to SHIFT for row 0, plane 0 and pulse frame_start.
- SHIFT: COLS pixels. Each pixel lasts 2*CLK_DIV clk.
  - Data outputs update at pixel start with hub75_clk low; hub75_clk is high for the second CLK_DIV cycles.
  - rd_addr is presented one clk before the data is registered.
  - Plane p takes bit p of each channel field; R is the MSB field.
  - hub75_oe stays at the previous DISPLAY result (OE is 1 here, since DISPLAY always ends high). hub75_clk returns low after the last pixel.
- BLANK_PRE: oe=1 for BLANK_CYCLES. On the first cycle of plane 0, hub75_addr updates to the new row.
- LATCH: hub75_latch=1 for exactly one clk.
- DISPLAY: oe=0 for on_p = ((BASE_ON << p) * (brightness+1)) >> 8 clk.
  - If on_p = 0, oe stays high and the state is 1 clk long.
  - The product uses full width; no truncation before the shift.
- BLANK_POST: oe=1 for BLANK_CYCLES. Then advance:
  - p < BITS_PER_CHANNEL-1: p+1, same row.
  - Otherwise: p=0, row+1.
  - At the last row and last plane, the frame ends.
- Frame end, processed in this order:
  1. If swap_req=1, toggle rd_buf and pulse swap_ack for one clk. At most one swap per frame; swap_req must drop before the next frame end to avoid a second flip.
  2. If enable=1, start the next frame (SHIFT, frame_start pulse). Otherwise go to IDLE.
- Deasserting enable mid-frame has no effect until frame end.
- hub75_addr never changes while oe=0. hub75_latch is never high while hub75_clk is high.
- Brightness is sampled at DISPLAY entry. Changes mid-DISPLAY apply from the next plane.

Test Plan:
(Small config: COLS=4, ROW_ADDR_BITS=1, BITS_PER_CHANNEL=2, CLK_DIV=1, BASE_ON=4, BLANK_CYCLES=2.)
1. Reset: hold n_reset low -> oe=1, clk/latch/colours/addr=0, rd_buf=0. Release with enable=0 -> outputs unchanged for 100 clk.
2. Shift data: top pixels R=2'b01, G=2'b10, B=2'b11, bottom all 0; enable=1. -> Plane 0 shows 4 hub75_clk rising edges with red=01, green=00, blue=01, then one latch pulse. Plane 1 shows red=00, green=01, blue=01. rd_addr leads data by 1 clk.
3. Brightness 255 -> oe low 4 clk (plane 0) and 8 clk (plane 1). Brightness 127 -> 2 and 4 clk. Brightness 0 -> oe never low; frame still cycles.
4. Swap: assert swap_req mid row 0 -> rd_buf toggles only after row 1, plane 1 BLANK_POST. swap_ack is a single 1-clk pulse. Drop req after ack -> no further toggle on the next frame.
5. Enable drop: deassert enable during row 0 -> row 1 completes. Then IDLE with oe=1, clk=0, and no further frame_start.
6. Reset mid-DISPLAY (oe=0) -> oe=1 in the same cycle as n_reset falling. After release, the first frame_start occurs at row 0, plane 0.

Source files
------------

// File: rtl/hub75_scan_engine.sv
// HUB75 scan engine: shifts one bit plane of a row pair out of a double-buffered frame RAM,
// latches it, then lights it for a brightness-scaled binary-weighted on-time.
module hub75_scan_engine #(
    parameter int COLS             = 64,
    parameter int ROW_ADDR_BITS    = 4,
    parameter int BITS_PER_CHANNEL = 4,
    parameter int CLK_DIV          = 2,
    parameter int BASE_ON          = 32,
    parameter int BLANK_CYCLES     = 2
) (
    input  logic                                        clk,
    input  logic                                        n_reset,
    input  logic                                        enable,
    input  logic [7:0]                                  brightness,
    input  logic                                        swap_req,
    output logic                                        swap_ack,
    output logic                                        rd_buf,
    output logic [ROW_ADDR_BITS+$clog2(COLS)-1:0]       rd_addr,
    input  logic [3*BITS_PER_CHANNEL-1:0]               rd_data_top,
    input  logic [3*BITS_PER_CHANNEL-1:0]               rd_data_bottom,
    output logic [1:0]                                  hub75_red,
    output logic [1:0]                                  hub75_green,
    output logic [1:0]                                  hub75_blue,
    output logic [ROW_ADDR_BITS-1:0]                    hub75_addr,
    output logic                                        hub75_clk,
    output logic                                        hub75_latch,
    output logic                                        hub75_oe,
    output logic                                        frame_start
);

    localparam int COL_BITS   = $clog2(COLS);
    localparam int BPC        = BITS_PER_CHANNEL;
    localparam int PLANE_BITS = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int PHASE_BITS = $clog2(2 * CLK_DIV);
    localparam int MAX_ON     = BASE_ON << (BPC - 1);
    localparam int CNT_MAX    = (MAX_ON > BLANK_CYCLES) ? MAX_ON : BLANK_CYCLES;
    localparam int CNT_BITS   = $clog2(CNT_MAX + 1);
    localparam int PROD_BITS  = 48;

    localparam logic [PHASE_BITS-1:0]    PH_CLK_HI  = PHASE_BITS'(CLK_DIV - 1);
    localparam logic [PHASE_BITS-1:0]    PH_FETCH   = PHASE_BITS'(2 * CLK_DIV - 2);
    localparam logic [PHASE_BITS-1:0]    PH_LAST    = PHASE_BITS'(2 * CLK_DIV - 1);
    localparam logic [COL_BITS-1:0]      COL_LAST   = COL_BITS'(COLS - 1);
    localparam logic [ROW_ADDR_BITS-1:0] ROW_LAST   = '1;
    localparam logic [PLANE_BITS-1:0]    PLANE_LAST = PLANE_BITS'(BPC - 1);
    localparam logic [CNT_BITS-1:0]      BLANK_LOAD = CNT_BITS'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        BLANK_PRE,
        LATCH,
        DISPLAY,
        BLANK_POST
    } state_t;

    state_t                   state;
    logic [PLANE_BITS-1:0]    plane;
    logic [ROW_ADDR_BITS-1:0] row;
    logic [COL_BITS-1:0]      col;
    logic [PHASE_BITS-1:0]    phase;
    logic [CNT_BITS-1:0]      cnt;
    logic                     primed;

    logic [BPC-1:0]           top_r, top_g, top_b;
    logic [BPC-1:0]           bot_r, bot_g, bot_b;
    logic [1:0]               red_bits, green_bits, blue_bits;
    logic [PROD_BITS-1:0]     on_product;
    logic [CNT_BITS-1:0]      on_cycles;

    // NOTE: every combinational output gets a value on every path, so no latch can be inferred.
    always_comb begin
        top_r      = rd_data_top[3*BPC-1 -: BPC];
        top_g      = rd_data_top[2*BPC-1 -: BPC];
        top_b      = rd_data_top[BPC-1:0];
        bot_r      = rd_data_bottom[3*BPC-1 -: BPC];
        bot_g      = rd_data_bottom[2*BPC-1 -: BPC];
        bot_b      = rd_data_bottom[BPC-1:0];
        red_bits   = {bot_r[plane], top_r[plane]};
        green_bits = {bot_g[plane], top_g[plane]};
        blue_bits  = {bot_b[plane], top_b[plane]};
    end

    // Full-width product before the shift so low brightness does not lose the plane weight.
    always_comb begin
        on_product = (PROD_BITS'(BASE_ON) << plane) * (PROD_BITS'(brightness) + PROD_BITS'(1));
        on_cycles  = CNT_BITS'(on_product >> 8);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            plane       <= '0;
            row         <= '0;
            col         <= '0;
            phase       <= '0;
            cnt         <= '0;
            primed      <= 1'b0;
            rd_addr     <= '0;
            rd_buf      <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            hub75_red   <= '0;
            hub75_green <= '0;
            hub75_blue  <= '0;
            hub75_addr  <= '0;
            hub75_clk   <= 1'b0;
            hub75_latch <= 1'b0;
            hub75_oe    <= 1'b1;
        end else begin
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                IDLE: begin
                    hub75_oe  <= 1'b1;
                    hub75_clk <= 1'b0;
                    if (enable) begin
                        state       <= SHIFT;
                        plane       <= '0;
                        row         <= '0;
                        col         <= '0;
                        primed      <= 1'b0;
                        rd_addr     <= '0;
                        frame_start <= 1'b1;
                    end
                end

                SHIFT: begin
                    // First cycle only waits for the read data of column 0.
                    if (!primed) begin
                        primed      <= 1'b1;
                        phase       <= '0;
                        hub75_clk   <= 1'b0;
                        hub75_red   <= red_bits;
                        hub75_green <= green_bits;
                        hub75_blue  <= blue_bits;
                    end else begin
                        phase <= phase + 1'b1;
                        if (phase == PH_CLK_HI) begin
                            hub75_clk <= 1'b1;
                        end
                        if (phase == PH_FETCH && col != COL_LAST) begin
                            rd_addr <= {row, col + 1'b1};
                        end
                        if (phase == PH_LAST) begin
                            hub75_clk <= 1'b0;
                            phase     <= '0;
                            if (col == COL_LAST) begin
                                state <= BLANK_PRE;
                                cnt   <= BLANK_LOAD;
                                if (plane == '0) begin
                                    hub75_addr <= row;
                                end
                            end else begin
                                col         <= col + 1'b1;
                                hub75_red   <= red_bits;
                                hub75_green <= green_bits;
                                hub75_blue  <= blue_bits;
                            end
                        end
                    end
                end

                BLANK_PRE: begin
                    if (cnt == '0) begin
                        state       <= LATCH;
                        hub75_latch <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                LATCH: begin
                    hub75_latch <= 1'b0;
                    state       <= DISPLAY;
                    if (on_cycles == '0) begin
                        cnt <= '0;
                    end else begin
                        hub75_oe <= 1'b0;
                        cnt      <= on_cycles - 1'b1;
                    end
                end

                DISPLAY: begin
                    if (cnt == '0) begin
                        hub75_oe <= 1'b1;
                        state    <= BLANK_POST;
                        cnt      <= BLANK_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                BLANK_POST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        col    <= '0;
                        primed <= 1'b0;
                        if (plane != PLANE_LAST) begin
                            plane   <= plane + 1'b1;
                            state   <= SHIFT;
                            rd_addr <= {row, {COL_BITS{1'b0}}};
                        end else begin
                            plane <= '0;
                            row   <= row + 1'b1;
                            if (row != ROW_LAST) begin
                                state   <= SHIFT;
                                rd_addr <= {row + 1'b1, {COL_BITS{1'b0}}};
                            end else begin
                                // Frame end: flip first so the next frame reads the new buffer.
                                if (swap_req) begin
                                    rd_buf   <= ~rd_buf;
                                    swap_ack <= 1'b1;
                                end
                                rd_addr <= '0;
                                if (enable) begin
                                    state       <= SHIFT;
                                    frame_start <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hub75_scan_engine.sv
// Directed bench for hub75_scan_engine in the small configuration (4 cols, 2 rows, 2 planes).
module tb_hub75_scan_engine;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       enable;
    logic [7:0] brightness;
    logic       swap_req;
    logic       swap_ack;
    logic       rd_buf;
    logic [2:0] rd_addr;
    logic [5:0] rd_data_top;
    logic [5:0] rd_data_bottom;
    logic [1:0] hub75_red, hub75_green, hub75_blue;
    logic [0:0] hub75_addr;
    logic       hub75_clk, hub75_latch, hub75_oe, frame_start;

    int checks   = 0;
    int failures = 0;

    hub75_scan_engine #(
        .COLS(4), .ROW_ADDR_BITS(1), .BITS_PER_CHANNEL(2),
        .CLK_DIV(1), .BASE_ON(4), .BLANK_CYCLES(2)
    ) dut (
        .clk(clk), .n_reset(n_reset), .enable(enable), .brightness(brightness),
        .swap_req(swap_req), .swap_ack(swap_ack), .rd_buf(rd_buf), .rd_addr(rd_addr),
        .rd_data_top(rd_data_top), .rd_data_bottom(rd_data_bottom),
        .hub75_red(hub75_red), .hub75_green(hub75_green), .hub75_blue(hub75_blue),
        .hub75_addr(hub75_addr), .hub75_clk(hub75_clk), .hub75_latch(hub75_latch),
        .hub75_oe(hub75_oe), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame RAM indexed by {buffer, row, column}; data follows the address within the cycle.
    logic [5:0] mem_top    [0:15];
    logic [5:0] mem_bottom [0:15];
    assign rd_data_top    = mem_top[{rd_buf, rd_addr}];
    assign rd_data_bottom = mem_bottom[{rd_buf, rd_addr}];

    logic [15:0] idle_vec;
    logic [5:0]  rgb_now;
    assign idle_vec = {hub75_red, hub75_green, hub75_blue, hub75_addr, hub75_clk, hub75_latch,
                       hub75_oe, swap_ack, rd_buf, frame_start, rd_addr};
    assign rgb_now  = {hub75_red, hub75_green, hub75_blue};

    // Panel-side monitor, sampled on the falling edge.
    logic [5:0] caps[$];
    int         oe_runs[$];
    int         latch_addrs[$];
    int         frame_starts = 0;
    int         swap_acks    = 0;
    int         violations   = 0;
    int         oe_run       = 0;
    logic       prev_hclk    = 1'b0;
    logic       prev_oe      = 1'b1;
    logic [0:0] prev_addr    = 1'b0;

    always @(negedge clk) begin
        if (hub75_clk && !prev_hclk) caps.push_back(rgb_now);
        if (hub75_latch) latch_addrs.push_back(int'(hub75_addr));
        if (frame_start) frame_starts++;
        if (swap_ack) swap_acks++;
        if (!hub75_oe) begin
            oe_run++;
        end else if (!prev_oe) begin
            oe_runs.push_back(oe_run);
            oe_run = 0;
        end
        if (hub75_latch && hub75_clk) violations++;
        if (hub75_addr !== prev_addr && (!hub75_oe || !prev_oe)) violations++;
        prev_hclk = hub75_clk;
        prev_oe   = hub75_oe;
        prev_addr = hub75_addr;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task clear_monitors();
        caps.delete();
        oe_runs.delete();
        latch_addrs.delete();
        frame_starts = 0;
        swap_acks    = 0;
        oe_run       = 0;
    endtask

    task automatic wait_frame(input string tag, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < budget);
        check({tag, "_reached"}, frame_start, 1);
    endtask

    localparam logic [5:0] BUF0_P0 = 6'b01_00_01;
    localparam logic [5:0] BUF0_P1 = 6'b00_01_01;
    localparam logic [5:0] BUF1_P0 = 6'b00_10_10;

    initial begin
        int n;
        int exp_runs[4];
        int exp_addrs[4];

        n_reset    = 1'b0;
        enable     = 1'b0;
        brightness = 8'd255;
        swap_req   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem_top[i]    = (i < 8) ? 6'b01_10_11 : 6'b00_00_00;
            mem_bottom[i] = (i < 8) ? 6'b00_00_00 : 6'b10_01_11;
        end

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_oe", hub75_oe, 1);
        check("reset_outputs", idle_vec, 16'h0040);
        n_reset = 1'b1;
        clear_monitors();
        repeat (100) tick();
        check("idle_outputs", idle_vec, 16'h0040);
        check("idle_no_frame_start", frame_starts, 0);
        check("idle_no_hclk", caps.size(), 0);

        // First frame, full brightness
        enable = 1'b1;
        clear_monitors();
        tick();
        check("fs_pulse", frame_start, 1);
        check("c0_rd_addr", rd_addr, 0);
        tick();
        check("pix0_hclk_low", hub75_clk, 0);
        check("pix0_colours", rgb_now, BUF0_P0);
        check("fs_single", frame_start, 0);
        tick();
        check("pix0_hclk_high", hub75_clk, 1);
        check("rd_addr_lead", rd_addr, 1);
        tick();
        check("pix1_hclk_low", hub75_clk, 0);
        check("rd_addr_hold", rd_addr, 1);
        wait_frame("frame1", 200, n);
        check("frame1_len", n + 3, 80);
        check("frame1_rises", caps.size(), 16);
        for (int i = 0; i < 16 && i < caps.size(); i++)
            check($sformatf("frame1_rgb%0d", i), caps[i], ((i % 8) < 4) ? BUF0_P0 : BUF0_P1);
        exp_addrs = '{0, 0, 1, 1};
        check("frame1_latches", latch_addrs.size(), 4);
        for (int i = 0; i < 4 && i < latch_addrs.size(); i++)
            check($sformatf("frame1_latch_addr%0d", i), latch_addrs[i], exp_addrs[i]);
        exp_runs = '{4, 8, 4, 8};
        check("bright255_runs", oe_runs.size(), 4);
        for (int i = 0; i < 4 && i < oe_runs.size(); i++)
            check($sformatf("bright255_on%0d", i), oe_runs[i], exp_runs[i]);

        // Half brightness
        brightness = 8'd127;
        clear_monitors();
        wait_frame("frame2", 200, n);
        check("frame2_len", n, 68);
        exp_runs = '{2, 4, 2, 4};
        check("bright127_runs", oe_runs.size(), 4);
        for (int i = 0; i < 4 && i < oe_runs.size(); i++)
            check($sformatf("bright127_on%0d", i), oe_runs[i], exp_runs[i]);

        // Zero brightness: panel stays dark, frame keeps cycling
        brightness = 8'd0;
        clear_monitors();
        wait_frame("frame3", 200, n);
        check("frame3_len", n, 60);
        check("bright0_runs", oe_runs.size(), 0);
        check("bright0_latches", latch_addrs.size(), 4);

        // Buffer swap at frame end
        brightness = 8'd255;
        clear_monitors();
        repeat (10) tick();
        swap_req = 1'b1;
        check("swap_early_buf", rd_buf, 0);
        repeat (69) tick();
        check("swap_pending_buf", rd_buf, 0);
        check("swap_pending_ack", swap_ack, 0);
        tick();
        check("swap_ack_pulse", swap_ack, 1);
        check("swap_buf_flip", rd_buf, 1);
        check("swap_fs", frame_start, 1);
        tick();
        check("swap_ack_single", swap_ack, 0);
        check("swap_new_data", rgb_now, BUF1_P0);
        swap_req = 1'b0;
        wait_frame("frame5", 200, n);
        check("frame5_len", n, 79);
        check("no_second_flip", rd_buf, 1);
        check("swap_ack_count", swap_acks, 1);

        // Enable dropped during row 0
        tick();
        clear_monitors();
        repeat (4) tick();
        enable = 1'b0;
        repeat (180) tick();
        check("drop_rises", caps.size(), 16);
        check("drop_oe_runs", oe_runs.size(), 4);
        check("drop_latches", latch_addrs.size(), 4);
        if (latch_addrs.size() == 4) check("drop_last_row", latch_addrs[3], 1);
        check("drop_no_fs", frame_starts, 0);
        check("drop_idle_pins", {hub75_oe, hub75_clk, hub75_latch}, 3'b100);

        // Reset in the middle of DISPLAY
        enable = 1'b1;
        clear_monitors();
        tick();
        check("rst_test_fs", frame_start, 1);
        repeat (13) tick();
        check("display_oe_low", hub75_oe, 0);
        #2;
        n_reset = 1'b0;
        #1;
        check("async_reset_oe", hub75_oe, 1);
        check("async_reset_outputs", idle_vec, 16'h0040);
        tick();
        tick();
        n_reset = 1'b1;
        clear_monitors();
        tick();
        check("restart_fs", frame_start, 1);
        check("restart_rd_addr", rd_addr, 0);
        wait_frame("frame_after_reset", 200, n);
        check("restart_len", n, 80);
        if (caps.size() > 0) check("restart_first_rgb", caps[0], BUF0_P0);
        if (latch_addrs.size() > 0) check("restart_first_row", latch_addrs[0], 0);
        if (oe_runs.size() > 0) check("restart_plane0_on", oe_runs[0], 4);
        check("panel_invariants", violations, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
